// File: rtl/sim_run_controller.sv
// sim_run_controller: drives the harness reset pulse, watches per-harness pass/fail flags and ends the run as pass, fail or timeout.
module sim_run_controller #(
  parameter int N_HARNESS      = 1,
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 32,
  parameter bit RST_PIN_PULLUP = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rerun,
  input  logic [N_HARNESS-1:0] io_success,
  input  logic [N_HARNESS-1:0] io_fail,
  output logic                 harness_reset,
  output logic                 running,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [N_HARNESS-1:0] success_vec,
  output logic [N_HARNESS-1:0] fail_vec,
  output logic [CNT_W-1:0]     cycle_count
);
  typedef enum logic [2:0] {S_HOLD, S_RUN, S_PASS, S_FAIL, S_TOUT} state_e;
  localparam int HW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [63:0] TO_LAST = 64'(TIMEOUT_CYCLES) - 64'd1;
  localparam logic [63:0] CNT_MAX = CNT_W >= 64 ? '1 : (64'd1 << CNT_W) - 64'd1;
  localparam logic HR_ON = RST_PIN_PULLUP ? 1'b0 : 1'b1;
  if (TIMEOUT_CYCLES != 0 && TO_LAST > CNT_MAX) begin : g_sat_warn
    $warning("sim_run_controller: CNT_W too small, timeout can never fire");
  end
  state_e state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [N_HARNESS-1:0] succ_q, succ_d, fail_q, fail_d;
  logic hr_q, run_q, done_q, pass_q, to_q;
  logic timeout_hit;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (64'(cyc_q) == TO_LAST);
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cyc_d   = cyc_q;
    succ_d  = succ_q;
    fail_d  = fail_q;
    case (state_q)
      S_HOLD: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_LAST) begin
          state_d = S_RUN;
          hold_d  = '0;
          cyc_d   = '0;
        end
      end
      S_RUN: begin
        succ_d = succ_q | io_success;
        cyc_d  = &cyc_q ? cyc_q : cyc_q + 1'b1;
        if (|io_fail) begin
          state_d = S_FAIL;
          fail_d  = io_fail;
        end else if (&succ_d) state_d = S_PASS;
        else if (timeout_hit) state_d = S_TOUT;
      end
      default: if (rerun) begin
        state_d = S_HOLD;
        hold_d  = '0;
        cyc_d   = '0;
        succ_d  = '0;
        fail_d  = '0;
      end
    endcase
  end
  // Flags are registered from the next state so every output is a flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_HOLD;
      hold_q  <= '0;
      cyc_q   <= '0;
      succ_q  <= '0;
      fail_q  <= '0;
      hr_q    <= HR_ON;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cyc_q   <= cyc_d;
      succ_q  <= succ_d;
      fail_q  <= fail_d;
      hr_q    <= state_d == S_HOLD ? HR_ON : ~HR_ON;
      run_q   <= state_d == S_RUN;
      done_q  <= state_d == S_PASS || state_d == S_FAIL || state_d == S_TOUT;
      pass_q  <= state_d == S_PASS;
      to_q    <= state_d == S_TOUT;
    end
  end
  assign harness_reset = hr_q;
  assign running       = run_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = to_q;
  assign success_vec   = succ_q;
  assign fail_vec      = fail_q;
  assign cycle_count   = cyc_q;
endmodule

// File: tb/tb_sim_run_controller.sv
// tb_sim_run_controller: directed vector table plus hand sequences for reset, polarity, saturation and async reset.
module tb_sim_run_controller;
  logic clock = 1'b0, reset = 1'b1, rerun = 1'b0;
  logic [2:0] s = '0, f = '0;
  logic m_hr, m_run, m_dn, m_ps, m_to;
  logic [2:0] m_sv, m_fv;
  logic [31:0] m_cc;
  logic p_hr, p_run, p_dn, p_ps, p_to;
  logic [0:0] p_sv, p_fv;
  logic [3:0] p_cc;
  logic p_s = 1'b0, p_f = 1'b0;
  int tests = 0, fails = 0;

  sim_run_controller #(.N_HARNESS(3), .RESET_CYCLES(2), .TIMEOUT_CYCLES(50), .CNT_W(32), .RST_PIN_PULLUP(1'b1)) dut (
    .clock(clock), .reset(reset), .rerun(rerun), .io_success(s), .io_fail(f),
    .harness_reset(m_hr), .running(m_run), .done(m_dn), .pass(m_ps), .timeout(m_to),
    .success_vec(m_sv), .fail_vec(m_fv), .cycle_count(m_cc));

  sim_run_controller #(.N_HARNESS(1), .RESET_CYCLES(2), .TIMEOUT_CYCLES(0), .CNT_W(4), .RST_PIN_PULLUP(1'b0)) dut_pol (
    .clock(clock), .reset(reset), .rerun(1'b0), .io_success(p_s), .io_fail(p_f),
    .harness_reset(p_hr), .running(p_run), .done(p_dn), .pass(p_ps), .timeout(p_to),
    .success_vec(p_sv), .fail_vec(p_fv), .cycle_count(p_cc));

  always #5 clock = ~clock;

  typedef struct {
    logic rr; logic [2:0] s, f; int n;
    logic hr, run, dn, ps, to; logic [2:0] sv, fv; logic [31:0] cc;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic rr, logic [2:0] vs, vf, int n, logic hr, run, dn, ps, to,
                              logic [2:0] sv, fv, logic [31:0] cc);
    vec_t v;
    v.rr = rr; v.s = vs; v.f = vf; v.n = n;
    v.hr = hr; v.run = run; v.dn = dn; v.ps = ps; v.to = to;
    v.sv = sv; v.fv = fv; v.cc = cc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [63:0] main_st();
    return 64'({m_hr, m_run, m_dn, m_ps, m_to, m_sv, m_fv, m_cc});
  endfunction

  function automatic logic [63:0] exp_st(logic hr, run, dn, ps, to, logic [2:0] sv, fv, logic [31:0] cc);
    return 64'({hr, run, dn, ps, to, sv, fv, cc});
  endfunction

  initial begin
    // rr s f n | hr run dn ps to | sv fv cc
    tbl.push_back(mk(0, 3'b000, 3'b000,  4, 1, 1, 0, 0, 0, 3'b000, 3'b000,  4));
    tbl.push_back(mk(0, 3'b001, 3'b000,  1, 1, 1, 0, 0, 0, 3'b001, 3'b000,  5));
    tbl.push_back(mk(0, 3'b000, 3'b000,  3, 1, 1, 0, 0, 0, 3'b001, 3'b000,  8));
    tbl.push_back(mk(0, 3'b100, 3'b000,  1, 1, 1, 0, 0, 0, 3'b101, 3'b000,  9));
    tbl.push_back(mk(1, 3'b000, 3'b000,  1, 1, 1, 0, 0, 0, 3'b101, 3'b000, 10));
    tbl.push_back(mk(0, 3'b000, 3'b000,  9, 1, 1, 0, 0, 0, 3'b101, 3'b000, 19));
    tbl.push_back(mk(0, 3'b010, 3'b000,  1, 1, 0, 1, 1, 0, 3'b111, 3'b000, 20));
    tbl.push_back(mk(0, 3'b111, 3'b111,  3, 1, 0, 1, 1, 0, 3'b111, 3'b000, 20));
    tbl.push_back(mk(1, 3'b000, 3'b000,  1, 0, 0, 0, 0, 0, 3'b000, 3'b000,  0));
    tbl.push_back(mk(0, 3'b000, 3'b000,  1, 0, 0, 0, 0, 0, 3'b000, 3'b000,  0));
    tbl.push_back(mk(0, 3'b000, 3'b000,  1, 1, 1, 0, 0, 0, 3'b000, 3'b000,  0));
    tbl.push_back(mk(0, 3'b000, 3'b000,  6, 1, 1, 0, 0, 0, 3'b000, 3'b000,  6));
    tbl.push_back(mk(0, 3'b111, 3'b010,  1, 1, 0, 1, 0, 0, 3'b111, 3'b010,  7));
    tbl.push_back(mk(1, 3'b000, 3'b000,  1, 0, 0, 0, 0, 0, 3'b000, 3'b000,  0));
    tbl.push_back(mk(0, 3'b000, 3'b000,  2, 1, 1, 0, 0, 0, 3'b000, 3'b000,  0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 49, 1, 1, 0, 0, 0, 3'b000, 3'b000, 49));
    tbl.push_back(mk(0, 3'b000, 3'b000,  1, 1, 0, 1, 0, 1, 3'b000, 3'b000, 50));
    tbl.push_back(mk(0, 3'b000, 3'b000,  5, 1, 0, 1, 0, 1, 3'b000, 3'b000, 50));
    tbl.push_back(mk(1, 3'b000, 3'b000,  1, 0, 0, 0, 0, 0, 3'b000, 3'b000,  0));
    tbl.push_back(mk(0, 3'b000, 3'b000,  2, 1, 1, 0, 0, 0, 3'b000, 3'b000,  0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 49, 1, 1, 0, 0, 0, 3'b000, 3'b000, 49));
    tbl.push_back(mk(0, 3'b000, 3'b001,  1, 1, 0, 1, 0, 0, 3'b000, 3'b001, 50));
    tbl.push_back(mk(0, 3'b000, 3'b000,  2, 1, 0, 1, 0, 0, 3'b000, 3'b001, 50));

    step(2);
    chk("reset_main", main_st(), exp_st(0, 0, 0, 0, 0, 3'b000, 3'b000, 0));
    chk("reset_pol_hr", 64'(p_hr), 64'd1);
    reset = 1'b0;
    step(1);
    chk("hold_edge1_main", main_st(), exp_st(0, 0, 0, 0, 0, 3'b000, 3'b000, 0));
    chk("hold_edge1_pol", 64'({p_hr, p_run}), 64'b10);
    step(1);
    chk("run_start_main", main_st(), exp_st(1, 1, 0, 0, 0, 3'b000, 3'b000, 0));
    chk("run_start_pol", 64'({p_hr, p_run}), 64'b01);

    foreach (tbl[i]) begin
      rerun = tbl[i].rr; s = tbl[i].s; f = tbl[i].f;
      step(tbl[i].n);
      chk($sformatf("vec%0d", i), main_st(),
          exp_st(tbl[i].hr, tbl[i].run, tbl[i].dn, tbl[i].ps, tbl[i].to, tbl[i].sv, tbl[i].fv, tbl[i].cc));
    end
    rerun = 1'b0; s = '0; f = '0;

    chk("pol_saturate", 64'({p_hr, p_run, p_dn, p_cc}), 64'({1'b0, 1'b1, 1'b0, 4'hF}));

    rerun = 1'b1;
    step(1);
    rerun = 1'b0;
    step(32);
    chk("run_cycle30", main_st(), exp_st(1, 1, 0, 0, 0, 3'b000, 3'b000, 30));
    #2 reset = 1'b1;
    #1;
    chk("async_rst_main", main_st(), exp_st(0, 0, 0, 0, 0, 3'b000, 3'b000, 0));
    chk("async_rst_pol", 64'({p_hr, p_run, p_cc}), 64'({1'b1, 1'b0, 4'h0}));
    #2 reset = 1'b0;
    step(1);
    chk("rehold_edge1", main_st(), exp_st(0, 0, 0, 0, 0, 3'b000, 3'b000, 0));
    step(1);
    chk("rerun_edge2", main_st(), exp_st(1, 1, 0, 0, 0, 3'b000, 3'b000, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
